alu_seq_muldiv: RTL and testbench
=================================

// Module: alu_seq_muldiv
// PURPOSE
//  Parametrised, handshaked ALU for the multi-cycle core; next generation of the single-cycle ALU.
//  - Wider opcode set: RV32 integer ops plus iterative multiply and divide (M-subset).
//  - Registered result with a zero flag.
//  - Valid/ready handshake on both sides.
//  Sits between the decode/operand-fetch stage and writeback.
// PARAMETERS
//  WIDTH  32  datapath width; power of two, >= 8
// PORTS
//  clk        in   1      single clock; all state updates on rising edge
//  rst_n      in   1      synchronous, active-low reset
//  in_valid   in   1      operands/op valid
//  in_ready   out  1      block can accept an op
//  SrcA       in   WIDTH  operand A
//  SrcB       in   WIDTH  operand B
//  ALUControl in   4      opcode (table below)
//  out_valid  out  1      ALUResult/Zero valid
//  out_ready  in   1      consumer takes result
//  ALUResult  out  WIDTH  registered result
//  Zero       out  1      1 when ALUResult == 0; registered with the result
//  busy       out  1      1 in MUL or DIV state
// BEHAVIOUR
//  Reset (rst_n==0 at clk edge):
//  - state=IDLE; ALUResult=0, Zero=0, out_valid=0, busy=0, in_ready=0.
//  - in_ready=1 from the first cycle after reset deasserts.
//  - Reset mid-operation aborts the op; the partial result is discarded.
//  Opcodes:
//    0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR
//    5 SLT (signed), 6 SLTU; both give result 1 or 0
//    7 SLL, 8 SRL, 9 SRA; shift amount = SrcB[log2(WIDTH)-1:0]
//    A MUL (low WIDTH bits), B MULHU (high WIDTH bits, unsigned)
//    C DIVU, D REMU, E DIV, F REM (signed, truncate toward zero)
//  Handshake:
//  - An op is accepted when in_valid && in_ready.
//  - Operands and opcode are latched on accept and are ignored at all other times.
//  - in_ready = (state==IDLE).
//  FSM states: IDLE, MUL, DIV, DONE.
//  - IDLE -> DONE when opcode 0-9 is accepted. Result is computed and registered that edge.
//    Latency 1: out_valid is high the cycle after accept.
//  - IDLE -> MUL when opcode A/B is accepted. Unsigned shift-add, one bit/cycle, 2*WIDTH-bit product.
//  - IDLE -> DIV when opcode C-F is accepted.
//    Restoring division on magnitudes, one bit/cycle; signs are fixed up at the end.
//  - MUL/DIV run exactly WIDTH cycles (counter 0..WIDTH-1), then go to DONE.
//    out_valid asserts WIDTH+1 cycles after the accept edge. Latency is fixed, including special cases.
//  - DONE: out_valid=1; ALUResult and Zero are held stable until out_ready=1.
//    DONE -> IDLE on out_ready. No new accept in DONE (max throughput 1 op / 2 cycles).
//  - out_ready is ignored outside DONE.
//  Arithmetic rules:
//  - Add, sub and mul wrap modulo 2^WIDTH. No overflow flag.
//  - Divide by zero: DIV/DIVU give all-ones; REM/REMU give SrcA.
//  - Signed overflow (SrcA = -2^(WIDTH-1), SrcB = -1): DIV gives SrcA; REM gives 0.
//  - Zero is computed from the final registered result, never from a stale value.
// TESTING
//  1. ADD 7+5, accept cycle N -> out_valid at N+1, ALUResult=12, Zero=0.
//     Hold out_ready=0 for 3 cycles -> result stable, in_ready=0.
//  2. SUB 9-9 -> ALUResult=0, Zero=1.
//     SLT 0xFFFFFFFF vs 1 -> 1; SLTU of the same operands -> 0.
//  3. SRA 0x80000000 by SrcB=0x24 (amount 4) -> 0xF8000000.
//     SLL 1 by 31 -> 0x80000000.
//  4. MUL 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001; MULHU of the same -> 0xFFFFFFFE.
//     out_valid exactly 33 cycles after accept; busy high for 32 cycles.
//  5. DIV -7/2 -> 0xFFFFFFFD, REM -> 0xFFFFFFFF.
//     DIVU 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5.
//     DIV 0x80000000/-1 -> 0x80000000, REM -> 0.
//  6. Deassert rst_n on cycle 10 of a DIV -> next cycle: IDLE, out_valid=0, ALUResult=0.
//     Then a new ADD 1+1 -> 2 with latency 1.
//     Also: in_valid while busy -> op not accepted.

Source files
------------

// File: rtl/alu_seq_muldiv.sv
// Handshaked ALU: single-cycle RV32 integer ops plus iterative shift-add multiply
// and restoring divide, one bit per cycle, with a registered result and zero flag.
module alu_seq_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [3:0]       ALUControl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic             busy
);
  localparam int SW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state, state_nxt;

  logic               live;       // low during reset so in_ready stays 0 until the first edge after it
  logic [3:0]         op;
  logic [WIDTH-1:0]   opa;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem, dvs;
  logic               negq, negr, dz;
  logic [SW-1:0]      cnt;
  logic               accept, last;

  assign accept    = in_valid && in_ready;
  assign last      = (cnt == SW'(WIDTH-1));
  assign in_ready  = live && (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == MUL) || (state == DIV);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) begin
        if (ALUControl >= 4'hC)      state_nxt = DIV;
        else if (ALUControl >= 4'hA) state_nxt = MUL;
        else                         state_nxt = DONE;
      end
      MUL, DIV: if (last) state_nxt = DONE;
      DONE:     if (out_ready) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // single-cycle ops straight from the ports
  logic [SW-1:0]    shamt;
  logic [WIDTH-1:0] simple;
  assign shamt = SrcB[SW-1:0];

  always_comb begin
    simple = '0;
    case (ALUControl)
      4'h0: simple = SrcA + SrcB;
      4'h1: simple = SrcA - SrcB;
      4'h2: simple = SrcA & SrcB;
      4'h3: simple = SrcA | SrcB;
      4'h4: simple = SrcA ^ SrcB;
      4'h5: simple = {{(WIDTH-1){1'b0}}, $signed(SrcA) < $signed(SrcB)};
      4'h6: simple = {{(WIDTH-1){1'b0}}, SrcA < SrcB};
      4'h7: simple = SrcA << shamt;
      4'h8: simple = SrcA >> shamt;
      4'h9: simple = WIDTH'($signed(SrcA) >>> shamt);
      default: simple = '0;
    endcase
  end

  // multiply step: conditionally add multiplicand into the upper half, shift right
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod_nxt;
  assign mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, opa} : '0);
  assign prod_nxt = {mul_sum, prod[WIDTH-1:1]};

  // restoring divide step on magnitudes
  logic [WIDTH:0]   trial, rsub;
  logic             ge;
  logic [WIDTH-1:0] quo_nxt, rem_nxt, qfix, rfix;
  assign trial   = {rem, quo[WIDTH-1]};
  assign rsub    = trial - {1'b0, dvs};
  assign ge      = (trial >= {1'b0, dvs});
  assign rem_nxt = ge ? rsub[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_nxt = {quo[WIDTH-2:0], ge};
  assign qfix    = dz ? '1  : (negq ? -quo_nxt : quo_nxt);
  assign rfix    = dz ? opa : (negr ? -rem_nxt : rem_nxt);

  logic [WIDTH-1:0] fin;
  logic             fin_en;
  always_comb begin
    fin    = simple;
    fin_en = 1'b0;
    case (state)
      IDLE: fin_en = accept && (ALUControl < 4'hA);
      MUL: begin
        fin    = op[0] ? prod_nxt[2*WIDTH-1:WIDTH] : prod_nxt[WIDTH-1:0];
        fin_en = last;
      end
      DIV: begin
        fin    = op[0] ? rfix : qfix;
        fin_en = last;
      end
      default: fin_en = 1'b0;
    endcase
  end

  logic sa, sb;
  assign sa = ALUControl[1] && SrcA[WIDTH-1];
  assign sb = ALUControl[1] && SrcB[WIDTH-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      live      <= 1'b0;
      op        <= '0;
      opa       <= '0;
      prod      <= '0;
      quo       <= '0;
      rem       <= '0;
      dvs       <= '0;
      negq      <= 1'b0;
      negr      <= 1'b0;
      dz        <= 1'b0;
      cnt       <= '0;
      ALUResult <= '0;
      Zero      <= 1'b0;
    end else begin
      live <= 1'b1;
      if (state == IDLE && accept) begin
        op   <= ALUControl;
        opa  <= SrcA;
        prod <= {{WIDTH{1'b0}}, SrcB};
        quo  <= sa ? -SrcA : SrcA;
        rem  <= '0;
        dvs  <= sb ? -SrcB : SrcB;
        negq <= sa ^ sb;
        negr <= sa;
        dz   <= (SrcB == '0);
        cnt  <= '0;
      end
      if (state == MUL) prod <= prod_nxt;
      if (state == DIV) begin
        quo <= quo_nxt;
        rem <= rem_nxt;
      end
      if (busy) cnt <= cnt + 1'b1;
      if (fin_en) begin
        ALUResult <= fin;
        Zero      <= (fin == '0);
      end
    end
  end
endmodule

// File: tb/tb_alu_seq_muldiv.sv
// Directed bench for alu_seq_muldiv: transaction-level arithmetic model plus a
// per-cycle compare process, and literal expectations for each directed vector.
module tb_alu_seq_muldiv;
  localparam int W = 32;

  logic         clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [3:0]   ALUControl = 4'h0;
  logic [W-1:0] SrcA = '0, SrcB = '0;
  logic         in_ready, out_valid, Zero, busy;
  logic [W-1:0] ALUResult;

  alu_seq_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .SrcA(SrcA), .SrcB(SrcB), .ALUControl(ALUControl), .out_valid(out_valid),
    .out_ready(out_ready), .ALUResult(ALUResult), .Zero(Zero), .busy(busy)
  );

  always #5 clk = ~clk;

  int nvec = 0, nerr = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] mdl(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint          sa, sb;
    longint unsigned ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = a;
    ub = b;
    p  = ua * ub;
    case (op)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h2: return a & b;
      4'h3: return a | b;
      4'h4: return a ^ b;
      4'h5: return (sa < sb) ? 1 : 0;
      4'h6: return (ua < ub) ? 1 : 0;
      4'h7: return a << b[4:0];
      4'h8: return a >> b[4:0];
      4'h9: return W'($signed(a) >>> b[4:0]);
      4'hA: return p[W-1:0];
      4'hB: return p[2*W-1:W];
      4'hC: return (b == 0) ? '1 : a / b;
      4'hD: return (b == 0) ? a : a % b;
      4'hE: begin
        if (b == 0) return '1;
        if (a == 32'h8000_0000 && b == '1) return a;
        return W'(sa / sb);
      end
      default: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == '1) return '0;
        return W'(sa % sb);
      end
    endcase
  endfunction

  // transaction-level model: result known at accept, appears after a fixed delay
  bit           m_live, m_valid;
  int           m_wait;
  logic [W-1:0] m_res, m_pend;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_live  <= 1'b0;
      m_wait  <= 0;
      m_valid <= 1'b0;
      m_res   <= '0;
    end else begin
      m_live <= 1'b1;
      if (m_valid) begin
        if (out_ready) m_valid <= 1'b0;
      end else if (m_wait != 0) begin
        m_wait <= m_wait - 1;
        if (m_wait == 1) begin
          m_valid <= 1'b1;
          m_res   <= m_pend;
        end
      end else if (m_live && in_valid) begin
        if (ALUControl >= 4'hA) begin
          m_wait <= W;
          m_pend <= mdl(ALUControl, SrcA, SrcB);
        end else begin
          m_valid <= 1'b1;
          m_res   <= mdl(ALUControl, SrcA, SrcB);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", W'(in_ready), W'(m_live && !m_valid && m_wait == 0));
      check("out_valid", W'(out_valid), W'(m_valid));
      check("busy", W'(busy), W'(m_wait != 0));
      if (m_valid) begin
        check("ALUResult", ALUResult, m_res);
        check("Zero", W'(Zero), W'(m_res == '0));
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_timeout", W'(in_ready), W'(1));
  endtask

  task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] e, input int hold);
    int n, nb, lat;
    lat = (op >= 4'hA) ? W + 1 : 1;
    check("model_pin", mdl(op, a, b), e);
    wait_ready();
    #1;
    in_valid = 1'b1; ALUControl = op; SrcA = a; SrcB = b;
    @(posedge clk);
    #1;
    // keep offering junk: it must not be taken while the op is in flight
    ALUControl = 4'h0; SrcA = $urandom; SrcB = $urandom;
    out_ready = (op >= 4'hA);
    n = 0; nb = 0;
    do begin
      @(negedge clk);
      n++;
      if (busy) nb++;
    end while (!out_valid && n < 100);
    #1;
    in_valid = 1'b0; out_ready = 1'b0;
    check("latency", W'(n), W'(lat));
    check("busy_cycles", W'(nb), W'(lat - 1));
    check("result", ALUResult, e);
    check("zero_flag", W'(Zero), W'(e == '0));
    repeat (hold) @(negedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a, b, e;
  } vec_t;
  vec_t vq[$];

  task automatic add(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] e);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.e = e;
    vq.push_back(v);
  endtask

  initial begin
    add(4'h0, 32'd7,        32'd5,        32'd12);
    add(4'h1, 32'd9,        32'd9,        32'd0);
    add(4'h5, 32'hFFFFFFFF, 32'd1,        32'd1);
    add(4'h6, 32'hFFFFFFFF, 32'd1,        32'd0);
    add(4'h9, 32'h80000000, 32'h24,       32'hF8000000);
    add(4'h7, 32'd1,        32'd31,       32'h80000000);
    add(4'hA, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);
    add(4'hB, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    add(4'hE, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD);
    add(4'hF, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF);
    add(4'hC, 32'd5,        32'd0,        32'hFFFFFFFF);
    add(4'hD, 32'd5,        32'd0,        32'd5);
    add(4'hE, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    add(4'hF, 32'h80000000, 32'hFFFFFFFF, 32'd0);
    add(4'h2, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000);
    add(4'h3, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'hFFFFFFFF);
    add(4'h4, 32'hAAAAAAAA, 32'hFFFFFFFF, 32'h55555555);
    add(4'h8, 32'h80000000, 32'd31,       32'd1);
    add(4'h0, 32'hFFFFFFFF, 32'd1,        32'd0);
    add(4'h1, 32'd0,        32'd1,        32'hFFFFFFFF);
    add(4'hA, 32'd12345,    32'd10,       32'h0001E23A);
    add(4'hB, 32'h80000000, 32'd4,        32'd2);
    add(4'hC, 32'd100,      32'd7,        32'd14);
    add(4'hD, 32'd100,      32'd7,        32'd2);
    add(4'hE, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD);
    add(4'hF, 32'd7,        32'hFFFFFFFE, 32'd1);
    add(4'hE, 32'd0,        32'd5,        32'd0);
    add(4'hE, 32'd5,        32'd0,        32'hFFFFFFFF);
    add(4'hF, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB);

    rst_n = 1'b0;
    @(posedge clk);
    chk_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_result", ALUResult, '0);
    check("rst_zero", W'(Zero), '0);
    check("rst_out_valid", W'(out_valid), '0);
    check("rst_in_ready", W'(in_ready), '0);
    check("rst_busy", W'(busy), '0);
    #1 rst_n = 1'b1;

    foreach (vq[i]) do_op(vq[i].op, vq[i].a, vq[i].b, vq[i].e, (i == 0) ? 3 : 1);

    // reset in the middle of a divide discards it
    wait_ready();
    #1;
    in_valid = 1'b1; ALUControl = 4'hE; SrcA = 32'd100; SrcB = 32'd7;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(negedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("abort_out_valid", W'(out_valid), '0);
    check("abort_result", ALUResult, '0);
    check("abort_busy", W'(busy), '0);
    do_op(4'h0, 32'd1, 32'd1, 32'd2, 0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #500000;
    nerr++;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
